// File: rtl/sgbm_census.sv
// 3x3 census transform of left/right grey streams with raster-position tracking.
// Optional frame_done pulse enabled by defining SGBM_CENSUS_FRAME_DONE_EN.
module sgbm_census #(
   parameter int unsigned image_row = 200,
   parameter int unsigned image_col = 400
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_left,
   input  logic [7:0] in_right,
   input  logic [9:0] in_row,
   input  logic [9:0] in_col,
   output logic       out_valid,
   output logic [7:0] census_left,
   output logic [7:0] census_right,
   output logic [9:0] out_row,
   output logic [9:0] out_col
`ifdef SGBM_CENSUS_FRAME_DONE_EN
   ,
   output logic       frame_done
`endif
);

   localparam int unsigned AddrW = (image_col > 1) ? $clog2(image_col) : 1;
   localparam logic [9:0] RowLast = 10'(image_row - 1);
   localparam logic [9:0] ColLast = 10'(image_col - 1);

   typedef enum logic [0:0] {StWaitSof, StRun} state_e;

   state_e           r_state, w_state_next;
   logic [9:0]       r_exp_row, r_exp_col, w_exp_row_next, w_exp_col_next;
   logic             w_accept, w_origin, w_in_range, w_match;
   logic [AddrW-1:0] w_addr;

   logic [7:0] r_lb1_l [image_col];
   logic [7:0] r_lb2_l [image_col];
   logic [7:0] r_lb1_r [image_col];
   logic [7:0] r_lb2_r [image_col];

   logic       r_s1_acc, r_s1_emit;
   logic [9:0] r_s1_row, r_s1_col;
   logic [7:0] r_s1_pix_l, r_s1_pix_r, r_s1_lb1_l, r_s1_lb2_l, r_s1_lb1_r, r_s1_lb2_r;

   // Window indexed [col][row]: col 0 is the oldest column, row 0 is the top row
   logic [2:0][2:0][7:0] r_win_l, r_win_r;
   logic                 r_s2_valid;
   logic [9:0]           r_s2_row, r_s2_col;

   logic       r_out_valid, r_frame_done;
   logic [7:0] r_census_l, r_census_r;
   logic [9:0] r_out_row, r_out_col;

   assign w_origin   = (in_row == 10'd0) && (in_col == 10'd0);
   assign w_in_range = (in_row <= RowLast) && (in_col <= ColLast);
   assign w_match    = (in_row == r_exp_row) && (in_col == r_exp_col);
   assign w_addr     = in_col[AddrW-1:0];

   always_comb begin
      w_state_next   = r_state;
      w_accept       = 1'b0;
      w_exp_row_next = r_exp_row;
      w_exp_col_next = r_exp_col;
      if (in_valid) begin
         unique case (r_state)
            StWaitSof: begin
               if (w_origin) begin
                  w_accept     = 1'b1;
                  w_state_next = StRun;
               end
            end
            StRun: begin
               // An unexpected (0,0) restarts the frame instead of resyncing
               if (w_in_range && (w_match || w_origin)) w_accept = 1'b1;
               else w_state_next = StWaitSof;
            end
            default: w_state_next = StWaitSof;
         endcase
      end
      if (w_accept) begin
         if (in_col == ColLast) begin
            w_exp_col_next = 10'd0;
            w_exp_row_next = (in_row == RowLast) ? 10'd0 : in_row + 10'd1;
         end else begin
            w_exp_col_next = in_col + 10'd1;
            w_exp_row_next = in_row;
         end
      end
   end

   function automatic logic [7:0] census(input logic [2:0][2:0][7:0] w);
      logic [7:0] c;
      c = w[1][1];
      census = {w[0][0] < c, w[1][0] < c, w[2][0] < c, w[0][1] < c,
                w[2][1] < c, w[0][2] < c, w[1][2] < c, w[2][2] < c};
   endfunction

   // Line buffers and window: data only, never cleared
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_s1_lb1_l      <= r_lb1_l[w_addr];
         r_s1_lb2_l      <= r_lb2_l[w_addr];
         r_s1_lb1_r      <= r_lb1_r[w_addr];
         r_s1_lb2_r      <= r_lb2_r[w_addr];
         r_lb2_l[w_addr] <= r_lb1_l[w_addr];
         r_lb1_l[w_addr] <= in_left;
         r_lb2_r[w_addr] <= r_lb1_r[w_addr];
         r_lb1_r[w_addr] <= in_right;
         r_s1_pix_l      <= in_left;
         r_s1_pix_r      <= in_right;
      end
      if (r_s1_acc) begin
         r_win_l[0] <= r_win_l[1];
         r_win_l[1] <= r_win_l[2];
         r_win_l[2] <= {r_s1_pix_l, r_s1_lb1_l, r_s1_lb2_l};
         r_win_r[0] <= r_win_r[1];
         r_win_r[1] <= r_win_r[2];
         r_win_r[2] <= {r_s1_pix_r, r_s1_lb1_r, r_s1_lb2_r};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StWaitSof;
         r_exp_row    <= 10'd0;
         r_exp_col    <= 10'd0;
         r_s1_acc     <= 1'b0;
         r_s1_emit    <= 1'b0;
         r_s1_row     <= 10'd0;
         r_s1_col     <= 10'd0;
         r_s2_valid   <= 1'b0;
         r_s2_row     <= 10'd0;
         r_s2_col     <= 10'd0;
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_census_l   <= 8'd0;
         r_census_r   <= 8'd0;
         r_out_row    <= 10'd0;
         r_out_col    <= 10'd0;
      end else begin
         r_state    <= w_state_next;
         r_exp_row  <= w_exp_row_next;
         r_exp_col  <= w_exp_col_next;
         r_s1_acc   <= w_accept;
         r_s1_emit  <= w_accept && (in_row >= 10'd2) && (in_col >= 10'd2);
         if (w_accept) begin
            r_s1_row <= in_row;
            r_s1_col <= in_col;
         end
         r_s2_valid <= r_s1_emit;
         if (r_s1_emit) begin
            r_s2_row <= r_s1_row - 10'd1;
            r_s2_col <= r_s1_col - 10'd1;
         end
         r_out_valid  <= r_s2_valid;
         r_frame_done <= r_s2_valid && (r_s2_row == RowLast - 10'd1) &&
                         (r_s2_col == ColLast - 10'd1);
         if (r_s2_valid) begin
            r_census_l <= census(r_win_l);
            r_census_r <= census(r_win_r);
            r_out_row  <= r_s2_row;
            r_out_col  <= r_s2_col;
         end
      end
   end

   assign out_valid    = r_out_valid;
   assign census_left  = r_census_l;
   assign census_right = r_census_r;
   assign out_row      = r_out_row;
   assign out_col      = r_out_col;
`ifdef SGBM_CENSUS_FRAME_DONE_EN
   assign frame_done   = r_frame_done;
`else
   logic w_unused;
   assign w_unused = r_frame_done;
`endif

endmodule
